acs_sweep_ctrl: RTL and testbench

Time-multiplexing scheduler for the shared add-compare-select unit of the Viterbi decoder. Per received 2-bit channel symbol it sweeps all trellis states, one per cycle, through a single ACS instance. For each state it feeds the ACS the two predecessor path metrics and Hamming branch metrics, then captures the winning cost, decision bit and validity into a double-buffered path-metric store. It emits one survivor word per symbol to the traceback stage.

---
 rtl/acs_sweep_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_acs_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_sweep_ctrl.sv
// Sweeps all trellis states for each received symbol through a single shared ACS unit.
// The optional ACS_SWEEP_NORM_EN macro subtracts last symbol's minimum metric from the ACS inputs.
module acs_sweep_ctrl #(
  parameter  int unsigned NS_LOG2 = 3,
  localparam int unsigned N       = 1 << NS_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sym,
  output logic [NS_LOG2-1:0] trel_state,
  input  logic [1:0]         trel_cw0,
  input  logic [1:0]         trel_cw1,
  output logic               acs_path_0_valid,
  output logic               acs_path_1_valid,
  output logic [1:0]         acs_path_0_bmc,
  output logic [1:0]         acs_path_1_bmc,
  output logic [7:0]         acs_path_0_pmc,
  output logic [7:0]         acs_path_1_pmc,
  input  logic               acs_selection,
  input  logic               acs_valid_o,
  input  logic [7:0]         acs_path_cost,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       surv_bits,
  output logic [N-1:0]       surv_mask
);

  localparam int unsigned PMW = 8;

  typedef enum logic [1:0] {IDLE, SWEEP, OUT} state_e;

  state_e             state_q, state_d;
  logic [NS_LOG2-1:0] s_q, s_d;
  logic [1:0]         sym_q, sym_d;
  logic [PMW-1:0]     old_pm_q [N];
  logic [PMW-1:0]     old_pm_d [N];
  logic [PMW-1:0]     new_pm_q [N];
  logic [PMW-1:0]     new_pm_d [N];
  logic [N-1:0]       old_vld_q, old_vld_d;
  logic [N-1:0]       new_vld_q, new_vld_d;
  logic [N-1:0]       surv_q, surv_d;
  logic [NS_LOG2-1:0] pred0, pred1;
  logic [PMW-1:0]     norm_off;

  function automatic logic [1:0] popcnt2(input logic [1:0] x);
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      sym_q     <= '0;
      old_pm_q  <= '{default: '0};
      new_pm_q  <= '{default: '0};
      old_vld_q <= N'(1);
      new_vld_q <= '0;
      surv_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      sym_q     <= sym_d;
      old_pm_q  <= old_pm_d;
      new_pm_q  <= new_pm_d;
      old_vld_q <= old_vld_d;
      new_vld_q <= new_vld_d;
      surv_q    <= surv_d;
    end
  end

  // Sequencing and capture of ACS results; clear overrides every transition
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    sym_d     = sym_q;
    old_pm_d  = old_pm_q;
    new_pm_d  = new_pm_q;
    old_vld_d = old_vld_q;
    new_vld_d = new_vld_q;
    surv_d    = surv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sym_d   = in_sym;
          s_d     = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        new_pm_d[s_q]  = acs_path_cost;
        new_vld_d[s_q] = acs_valid_o;
        surv_d[s_q]    = acs_selection;
        s_d            = s_q + NS_LOG2'(1);
        if (s_q == NS_LOG2'(N - 1)) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          old_pm_d  = new_pm_q;
          old_vld_d = new_vld_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d   = IDLE;
      s_d       = '0;
      old_pm_d  = '{default: '0};
      new_pm_d  = '{default: '0};
      old_vld_d = N'(1);
      new_vld_d = '0;
      surv_d    = '0;
    end
  end

`ifdef ACS_SWEEP_NORM_EN
  logic [PMW-1:0] offset_q, offset_d;
  logic [PMW-1:0] min_q, min_d;
  logic           min_found_q, min_found_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q    <= '0;
      min_q       <= '1;
      min_found_q <= 1'b0;
    end else begin
      offset_q    <= offset_d;
      min_q       <= min_d;
      min_found_q <= min_found_d;
    end
  end

  // Minimum valid cost of the current sweep becomes the next sweep's offset
  always_comb begin
    offset_d    = offset_q;
    min_d       = min_q;
    min_found_d = min_found_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          min_d       = '1;
          min_found_d = 1'b0;
        end
      end
      SWEEP: begin
        if (acs_valid_o && (!min_found_q || (acs_path_cost < min_q))) begin
          min_d       = acs_path_cost;
          min_found_d = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) offset_d = min_found_q ? min_q : '0;
      end
      default: offset_d = offset_q;
    endcase
    if (clear) begin
      offset_d    = '0;
      min_d       = '1;
      min_found_d = 1'b0;
    end
  end

  assign norm_off = offset_q;
`else
  assign norm_off = '0;
`endif

  assign pred0 = {s_q[NS_LOG2-2:0], 1'b0};
  assign pred1 = {s_q[NS_LOG2-2:0], 1'b1};

  // ACS operands are live only while sweeping
  always_comb begin
    acs_path_0_valid = 1'b0;
    acs_path_1_valid = 1'b0;
    acs_path_0_bmc   = '0;
    acs_path_1_bmc   = '0;
    acs_path_0_pmc   = '0;
    acs_path_1_pmc   = '0;
    if (state_q == SWEEP) begin
      acs_path_0_valid = old_vld_q[pred0];
      acs_path_1_valid = old_vld_q[pred1];
      acs_path_0_bmc   = popcnt2(trel_cw0 ^ sym_q);
      acs_path_1_bmc   = popcnt2(trel_cw1 ^ sym_q);
      acs_path_0_pmc   = PMW'(old_pm_q[pred0] - norm_off);
      acs_path_1_pmc   = PMW'(old_pm_q[pred1] - norm_off);
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign trel_state = s_q;
  assign surv_bits  = surv_q;
  assign surv_mask  = new_vld_q;

endmodule

// File: tb/tb_acs_sweep_ctrl.sv
// Bench for acs_sweep_ctrl: behavioural ACS, trellis ROM and whole-symbol reference model.
module tb_acs_sweep_ctrl;

  localparam int unsigned NS_LOG2 = 3;
  localparam int unsigned N       = 8;
`ifdef ACS_SWEEP_NORM_EN
  localparam logic [7:0] PM_LATE = 8'd0;
`else
  localparam logic [7:0] PM_LATE = 8'd2;
`endif

  logic               clk = 1'b0;
  logic               rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]         in_sym, trel_cw0, trel_cw1;
  logic [NS_LOG2-1:0] trel_state;
  logic               acs_path_0_valid, acs_path_1_valid, acs_selection, acs_valid_o;
  logic [1:0]         acs_path_0_bmc, acs_path_1_bmc;
  logic [7:0]         acs_path_0_pmc, acs_path_1_pmc, acs_path_cost;
  logic [N-1:0]       surv_bits, surv_mask;

  always #5 clk = ~clk;

  acs_sweep_ctrl #(.NS_LOG2(NS_LOG2)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .trel_state(trel_state), .trel_cw0(trel_cw0), .trel_cw1(trel_cw1),
    .acs_path_0_valid(acs_path_0_valid), .acs_path_1_valid(acs_path_1_valid),
    .acs_path_0_bmc(acs_path_0_bmc), .acs_path_1_bmc(acs_path_1_bmc),
    .acs_path_0_pmc(acs_path_0_pmc), .acs_path_1_pmc(acs_path_1_pmc),
    .acs_selection(acs_selection), .acs_valid_o(acs_valid_o), .acs_path_cost(acs_path_cost),
    .out_valid(out_valid), .out_ready(out_ready),
    .surv_bits(surv_bits), .surv_mask(surv_mask)
  );

  // Trellis ROM
  logic [1:0] rom0 [N];
  logic [1:0] rom1 [N];
  assign trel_cw0 = rom0[trel_state];
  assign trel_cw1 = rom1[trel_state];

  // Behavioural ACS: lower cost wins, ties go to predecessor 0, no valid input gives cost 0
  logic [7:0] c0, c1;
  always_comb begin
    c0 = acs_path_0_pmc + {6'b0, acs_path_0_bmc};
    c1 = acs_path_1_pmc + {6'b0, acs_path_1_bmc};
    acs_valid_o = acs_path_0_valid | acs_path_1_valid;
    if (acs_path_0_valid && acs_path_1_valid) acs_selection = (c1 < c0);
    else acs_selection = acs_path_1_valid;
    acs_path_cost = !acs_valid_o ? 8'd0 : (acs_selection ? c1 : c0);
  end

  // Reference model: whole trellis step per symbol
  int m_pm [N];
  bit m_vld [N];
  int m_off;
  int e_pm [N];
  bit e_vld [N];
  bit e_sel [N];
  int e_off;

  function automatic void model_reset();
    for (int s = 0; s < N; s++) begin
      m_pm[s] = 0;
      m_vld[s] = (s == 0);
    end
    m_off = 0;
  endfunction

  function automatic void model_step(input logic [1:0] sym);
    int p0, p1, a, b;
    bit sel;
    for (int s = 0; s < N; s++) begin
      p0 = (s * 2) % N;
      p1 = p0 + 1;
      a = (m_pm[p0] - m_off + $countones(rom0[s] ^ sym)) & 255;
      b = (m_pm[p1] - m_off + $countones(rom1[s] ^ sym)) & 255;
      sel = (m_vld[p0] && m_vld[p1]) ? (b < a) : m_vld[p1];
      e_vld[s] = m_vld[p0] | m_vld[p1];
      e_sel[s] = sel;
      e_pm[s]  = e_vld[s] ? (sel ? b : a) : 0;
    end
    e_off = 0;
`ifdef ACS_SWEEP_NORM_EN
    e_off = 256;
    for (int s = 0; s < N; s++) if (e_vld[s] && e_pm[s] < e_off) e_off = e_pm[s];
    if (e_off == 256) e_off = 0;
`endif
  endfunction

  function automatic void model_commit();
    for (int s = 0; s < N; s++) begin
      m_pm[s]  = e_pm[s];
      m_vld[s] = e_vld[s];
    end
    m_off = e_off;
  endfunction

  function automatic logic [21:0] exp_acs(input int s, input logic [1:0] sym);
    int p0, p1;
    p0 = (s * 2) % N;
    p1 = p0 + 1;
    return {m_vld[p0], m_vld[p1], 2'($countones(rom0[s] ^ sym)), 2'($countones(rom1[s] ^ sym)),
            8'(m_pm[p0] - m_off), 8'(m_pm[p1] - m_off)};
  endfunction

  function automatic logic [N-1:0] exp_word(input bit want_sel);
    logic [N-1:0] w;
    for (int s = 0; s < N; s++) w[s] = want_sel ? e_sel[s] : e_vld[s];
    return w;
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One symbol from accept to handshake; optional clear at sweep state abort_s or rst in OUT
  task automatic xfer(input logic [1:0] sym, input int hold, input int abort_s, input bit rst_out,
                      output logic [N-1:0] bits, output logic [N-1:0] mask,
                      output logic [7:0] pmc_s0);
    bit seen;
    bits = '0;
    mask = '0;
    pmc_s0 = '0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sym = sym;
    @(negedge clk);
    in_valid = 1'b0;
    in_sym = 2'($urandom);
    model_step(sym);
    for (int k = 0; k < N; k++) begin
      chk("trel_state", 32'(trel_state), 32'(k));
      chk("sweep_flags", {30'b0, in_ready, out_valid}, 32'd0);
      chk("acs_inputs", 32'({acs_path_0_valid, acs_path_1_valid, acs_path_0_bmc, acs_path_1_bmc,
                             acs_path_0_pmc, acs_path_1_pmc}), 32'(exp_acs(k, sym)));
      if (k == 0) pmc_s0 = acs_path_0_pmc;
      if (k == abort_s) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_idle", 32'({in_ready, out_valid, surv_bits, surv_mask}), 32'({1'b1, 1'b0, 16'h0}));
        seen = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
          if (out_valid) seen = 1'b1;
          @(negedge clk);
        end
        chk("abort_no_out", 32'(seen), 32'd0);
        model_reset();
        return;
      end
      @(negedge clk);
    end
    chk("out_latency", 32'(out_valid), 32'd1);
    bits = surv_bits;
    mask = surv_mask;
    chk("surv_bits", 32'(surv_bits), 32'(exp_word(1'b1)));
    chk("surv_mask", 32'(surv_mask), 32'(exp_word(1'b0)));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_sym = ~sym;
      out_ready = 1'b0;
      @(negedge clk);
      chk("out_hold", 32'({out_valid, in_ready, surv_bits, surv_mask}), 32'({1'b1, 1'b0, bits, mask}));
    end
    in_valid = 1'b0;
    if (rst_out) begin
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      chk("rst_in_out", 32'({in_ready, out_valid, surv_bits, surv_mask}), 32'({1'b1, 1'b0, 16'h0}));
      model_reset();
      return;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handshake", 32'({in_ready, out_valid}), 32'b10);
    model_commit();
  endtask

  typedef struct {
    logic [1:0] sym;
    logic [7:0] bits;
    logic [7:0] mask;
    logic [7:0] pmc0;
  } vec_t;

  initial begin
    vec_t         tv [4];
    logic [N-1:0] b, m;
    logic [7:0]   p;

    tv[0] = '{sym: 2'b00, bits: 8'h00, mask: 8'h11, pmc0: 8'd0};
    tv[1] = '{sym: 2'b11, bits: 8'h00, mask: 8'h55, pmc0: 8'd0};
    tv[2] = '{sym: 2'b00, bits: 8'h00, mask: 8'hFF, pmc0: PM_LATE};
    tv[3] = '{sym: 2'b11, bits: 8'hFF, mask: 8'hFF, pmc0: PM_LATE};

    for (int s = 0; s < N; s++) begin
      rom0[s] = 2'b00;
      rom1[s] = 2'b11;
    end
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_sym = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("reset_state", 32'({in_ready, out_valid, surv_bits, surv_mask}), 32'({1'b1, 1'b0, 16'h0}));
    chk("reset_acs_idle", 32'({acs_path_0_valid, acs_path_1_valid, acs_path_0_pmc, acs_path_1_pmc}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      xfer(tv[i].sym, (i == 0) ? 5 : 0, -1, 1'b0, b, m, p);
      chk("tv_bits", 32'(b), 32'(tv[i].bits));
      chk("tv_mask", 32'(m), 32'(tv[i].mask));
      chk("tv_pmc0", 32'(p), 32'(tv[i].pmc0));
    end

    // Clear at trel_state 3, then the first symbol must reproduce a fresh frame
    xfer(2'b11, 0, 3, 1'b0, b, m, p);
    xfer(2'b00, 0, -1, 1'b0, b, m, p);
    chk("after_clear_word", 32'({b, m}), 32'({8'h00, 8'h11}));

    // Reset with out_ready in OUT
    xfer(2'b11, 2, -1, 1'b1, b, m, p);
    xfer(2'b00, 0, -1, 1'b0, b, m, p);
    chk("after_rst_word", 32'({b, m}), 32'({8'h00, 8'h11}));

    // Randomised symbols, ROM contents, stalls, clears and aborts
    for (int it = 0; it < 60; it++) begin
      for (int s = 0; s < N; s++) begin
        rom0[s] = 2'($urandom);
        rom1[s] = 2'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
      end
      xfer(2'($urandom), $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, N - 1) : -1, 1'b0, b, m, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
